// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand/result bundle for the chunked sequential adder.
// The master drives a request with operands; the slave returns status and result.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands plus carry-in CHUNK bits per clock,
// with a registered carry between slices, a start/busy/done handshake, carry-out and signed overflow.
module seq_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = CHUNK + 1;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_chunk_adder: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              last;

  logic [WIDTH-1:0]  a_w;
  logic [WIDTH-1:0]  b_w;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_nxt;
  logic              carry_r;
  logic [IDXW-1:0]   idx;
  logic [CHUNK-1:0]  chunk_s;
  logic              chunk_c;
  logic              msb_cin;

  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (idx == IDXW'(NCHUNK - 1)) begin
          last      = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Back-to-back: a waiting request is taken straight from DONE.
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    {chunk_c, chunk_s} = {1'b0, a_w[idx*CHUNK +: CHUNK]}
                       + {1'b0, b_w[idx*CHUNK +: CHUNK]}
                       + CW'(carry_r);
    acc_nxt = acc;
    acc_nxt[idx*CHUNK +: CHUNK] = chunk_s;
    // Carry into the MSB recovered from the MSB sum bit; only meaningful on the last slice.
    msb_cin = a_w[WIDTH-1] ^ b_w[WIDTH-1] ^ acc_nxt[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_w     <= '0;
      b_w     <= '0;
      acc     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      a_w     <= bus.a;
      b_w     <= bus.b;
      carry_r <= bus.cin;
      acc     <= '0;
      idx     <= '0;
    end else if (state == S_RUN) begin
      acc     <= acc_nxt;
      carry_r <= chunk_c;
      idx     <= idx + IDXW'(1);
      if (last) begin
        sum_r  <= acc_nxt;
        cout_r <= chunk_c;
        ovf_r  <= msb_cin ^ chunk_c;
      end
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule
